// File: rtl/inst_fetch_unit.sv
// RV64 instruction fetch: owns the PC and keeps at most one imem request outstanding.
// Optional `FETCH_MISALIGN_CHECK_EN reports misaligned redirect targets as a fault instead of fetching.
module inst_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        out_fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    KILL  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q;
  logic [63:0] addr_q;
  logic        park_q;
  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic [63:0] out_pc_q;
  logic        out_fault_q;

  logic        redirect_misaligned;
  logic [63:0] redirect_target;
  logic        grant;
  logic        accept_rsp;
  logic        out_fire;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_target     = redirect_pc;
`else
  assign redirect_misaligned = 1'b0;
  assign redirect_target     = redirect_pc & ~64'd3;
`endif

  // Both handshakes transfer on a rising edge where valid and ready/gnt are high;
  // valid never waits on ready, and payload holds while valid is high and not accepted.
  assign out_fire   = out_valid_q & out_ready;
  assign imem_req   = (state_q == FETCH) && !park_q && (!out_valid_q || out_ready);
  assign imem_addr  = pc_q;
  assign grant      = imem_req & imem_gnt;
  assign accept_rsp = (state_q == WAIT) && imem_rvalid && !redirect_valid;

  assign out_valid  = out_valid_q;
  assign out_inst   = out_inst_q;
  assign out_pc     = out_pc_q;
  assign out_fault  = out_fault_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (grant) state_d = redirect_valid ? KILL : WAIT;
      WAIT: begin
        if (imem_rvalid)         state_d = FETCH;
        else if (redirect_valid) state_d = KILL;
      end
      KILL:    if (imem_rvalid) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      park_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_pc_q    <= 64'h0;
      out_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) addr_q <= pc_q;
      // A redirect overrides any response landing in the same cycle.
      if (redirect_valid) begin
        pc_q        <= redirect_target;
        park_q      <= redirect_misaligned;
        out_valid_q <= redirect_misaligned;
        out_fault_q <= redirect_misaligned;
        if (redirect_misaligned) begin
          out_inst_q <= 32'h0;
          out_pc_q   <= redirect_pc + 64'd4;
        end
      end else if (accept_rsp) begin
        pc_q        <= addr_q + 64'd4;
        out_valid_q <= 1'b1;
        out_inst_q  <= imem_rdata;
        out_pc_q    <= addr_q + 64'd4;
        out_fault_q <= 1'b0;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a randomized
// memory/decode environment checked against an in-order expected-output queue.
module tb_inst_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_fault;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [95:0] exp_q[$];

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_fault(out_fault), .dbg_state(dbg_state)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
  endtask

  // Leaves the DUT in FETCH with a request pending at RESET_PC.
  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
  endtask

  // Grants the pending request and returns data one cycle later; output valid on return.
  task automatic serve_one(input logic [31:0] data);
    out_ready = 1'b1; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data;
    tick();
    imem_rvalid = 1'b0;
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    n_tests += 6;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst: got %h expected 0", out_inst); end
    if (out_pc !== 64'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    if (out_fault !== 1'b0) begin n_fail++; $display("FAIL reset_out_fault: got %b expected 0", out_fault); end
    rst = 1'b0;
    #1;
    n_tests++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_first_cycle_req: got %b expected 0", imem_req); end
    tick();
    n_tests += 2;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_second_cycle_req: got %b expected 1", imem_req); end
    if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_second_cycle_addr: got %h expected %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_first_fetch();
    reset_dut();
    imem_gnt = 1'b1; out_ready = 1'b1;
    #1;
    n_tests += 2;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", imem_req); end
    if (imem_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL first_addr: got %h expected 80000000", imem_addr); end
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0517;
    #1;
    n_tests += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_wait_valid: got %b expected 0", out_valid); end
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL first_wait_req: got %b expected 0", imem_req); end
    tick();
    imem_rvalid = 1'b0;
    n_tests += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_out_valid: got %b expected 1", out_valid); end
    if (out_inst !== 32'h0000_0517) begin n_fail++; $display("FAIL first_out_inst: got %h expected 00000517", out_inst); end
    if (out_pc !== 64'h8000_0004) begin n_fail++; $display("FAIL first_out_pc: got %h expected 80000004", out_pc); end
  endtask

  task automatic test_stall();
    reset_dut();
    serve_one(32'h0000_0517);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests += 4;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
      if (out_inst !== 32'h0000_0517) begin n_fail++; $display("FAIL stall_inst[%0d]: got %h expected 00000517", i, out_inst); end
      if (out_pc !== 64'h8000_0004) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected 80000004", i, out_pc); end
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
      tick();
    end
    out_ready = 1'b1; imem_gnt = 1'b1;
    #1;
    n_tests += 2;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_release_req: got %b expected 1", imem_req); end
    if (imem_addr !== 64'h8000_0004) begin n_fail++; $display("FAIL stall_release_addr: got %h expected 80000004", imem_addr); end
    tick();
    imem_gnt = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_consumed: got %b expected 0", out_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
    tick();
    imem_rvalid = 1'b0;
    n_tests += 2;
    if (out_inst !== 32'h0010_0093) begin n_fail++; $display("FAIL stall_second_inst: got %h expected 00100093", out_inst); end
    if (out_pc !== 64'h8000_0008) begin n_fail++; $display("FAIL stall_second_pc: got %h expected 80000008", out_pc); end
  endtask

  task automatic test_redirect_wait();
    reset_dut();
    serve_one(32'h0000_0517);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
      #1;
      n_tests += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kill_valid[%0d]: got %b expected 0", i, out_valid); end
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL kill_req[%0d]: got %b expected 0", i, imem_req); end
      tick();
    end
    imem_rvalid = 1'b0;
    n_tests += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kill_dropped: got %b expected 0", out_valid); end
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL kill_refetch_req: got %b expected 1", imem_req); end
    if (imem_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL kill_refetch_addr: got %h expected 80000100", imem_addr); end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kill_late_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_redirect_rvalid();
    // Redirect coincident with the response: data dropped.
    reset_dut();
    serve_one(32'h0000_0517);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    imem_rvalid = 1'b0; redirect_valid = 1'b0;
    n_tests += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdrv_valid: got %b expected 0", out_valid); end
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rdrv_req: got %b expected 1", imem_req); end
    if (imem_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL rdrv_addr: got %h expected 80000100", imem_addr); end
    // Redirect while a held output is valid: output flushed.
    reset_dut();
    serve_one(32'h0000_0517);
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    n_tests += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdfl_valid: got %b expected 0", out_valid); end
    if (imem_addr !== 64'h8000_0200) begin n_fail++; $display("FAIL rdfl_addr: got %h expected 80000200", imem_addr); end
  endtask

  task automatic test_wrap();
    reset_dut();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n_tests += 2;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req: got %b expected 1", imem_req); end
    if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h expected fffffffffffffffc", imem_addr); end
    serve_one(32'h0000_0013);
    #1;
    n_tests += 4;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b expected 1", out_valid); end
    if (out_pc !== 64'h0) begin n_fail++; $display("FAIL wrap_out_pc: got %h expected 0", out_pc); end
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_next_req: got %b expected 1", imem_req); end
    if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_misalign();
    reset_dut();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    n_tests += 5;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req: got %b expected 0", imem_req); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid: got %b expected 1", out_valid); end
    if (out_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b expected 1", out_fault); end
    if (out_inst !== 32'h0) begin n_fail++; $display("FAIL mis_inst: got %h expected 0", out_inst); end
    if (out_pc !== 64'h8000_0106) begin n_fail++; $display("FAIL mis_pc: got %h expected 80000106", out_pc); end
    out_ready = 1'b1; imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_parked_req[%0d]: got %b expected 0", i, imem_req); end
    end
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    n_tests += 2;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mis_resume_req: got %b expected 1", imem_req); end
    if (imem_addr !== 64'h8000_0300) begin n_fail++; $display("FAIL mis_resume_addr: got %h expected 80000300", imem_addr); end
`else
    n_tests += 3;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mis_req: got %b expected 1", imem_req); end
    if (imem_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL mis_addr: got %h expected 80000100", imem_addr); end
    if (out_fault !== 1'b0) begin n_fail++; $display("FAIL mis_fault: got %b expected 0", out_fault); end
    serve_one(32'h0000_0517);
    n_tests += 2;
    if (out_pc !== 64'h8000_0104) begin n_fail++; $display("FAIL mis_out_pc: got %h expected 80000104", out_pc); end
    if (out_fault !== 1'b0) begin n_fail++; $display("FAIL mis_out_fault: got %b expected 0", out_fault); end
`endif
  endtask

  task automatic test_back_to_back();
    int  grants = 0;
    logic granted_prev = 1'b0;
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      imem_rvalid = granted_prev; imem_rdata = $urandom; imem_gnt = 1'b1;
      #1;
      granted_prev = imem_req & imem_gnt;
      if (granted_prev) grants++;
      tick();
    end
    imem_gnt = 1'b0; imem_rvalid = granted_prev;
    tick();
    imem_rvalid = 1'b0;
    n_tests++;
    if (grants !== 10) begin n_fail++; $display("FAIL b2b_throughput: got %0d grants expected 10", grants); end
  endtask

  task automatic test_random();
    logic [63:0] exp_fetch = RESET_PC;
    logic [63:0] pend_addr = 64'h0;
    logic        pend = 1'b0;
    int          delay = 0;
    logic        hold_prev = 1'b0;
    logic [95:0] held = 96'h0;
    logic [95:0] exp;
    reset_dut();
    exp_q.delete();
    for (int cyc = 0; cyc < 640; cyc++) begin
      out_ready   = (cyc >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
      imem_gnt    = (cyc >= 600) ? 1'b0 : 1'($urandom_range(0, 1));
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
        if (delay == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr); pend = 1'b0;
        end else begin
          delay--;
        end
      end
      #1;
      if (hold_prev) begin
        n_tests++;
        if (out_valid !== 1'b1 || {out_inst, out_pc} !== held) begin
          n_fail++;
          $display("FAIL rand_hold[%0d]: got v=%b %h expected v=1 %h", cyc, out_valid, {out_inst, out_pc}, held);
        end
      end
      hold_prev = out_valid & ~out_ready;
      held = {out_inst, out_pc};
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_unexpected_out[%0d]: got %h expected none", cyc, {out_inst, out_pc});
        end else begin
          exp = exp_q.pop_front();
          if ({out_inst, out_pc} !== exp) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: got %h expected %h", cyc, {out_inst, out_pc}, exp);
          end
        end
      end
      if (imem_req && imem_gnt) begin
        n_tests++;
        if (imem_addr !== exp_fetch) begin
          n_fail++;
          $display("FAIL rand_fetch_addr[%0d]: got %h expected %h", cyc, imem_addr, exp_fetch);
        end
        exp_q.push_back({mem_word(exp_fetch), exp_fetch + 64'd4});
        pend = 1'b1; pend_addr = exp_fetch; delay = $urandom_range(0, 2);
        exp_fetch = exp_fetch + 64'd4;
      end
      tick();
    end
    n_tests++;
    if (exp_q.size() != 0 || pend) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d outstanding expected 0", exp_q.size());
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
